// File: rtl/multi_cycle_control_if.sv
// Control bundle between the multi-cycle controller and its datapath.
// The datapath side (master) drives instruction fields and Zero and receives every control strobe.
interface multi_cycle_control_if;
   logic [5:0] Opcode;
   logic [5:0] FuncCode;
   logic       Zero;

   logic       PCWrite;
   logic       PCWriteCond;
   logic       PCEn;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic       RegDst;
   logic       MemToReg;
   logic       SignExtend;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [3:0] ALUOp;
   logic [1:0] PCSource;
   logic [3:0] State;
   logic       IllegalOp;
   logic       InstrDone;

   modport master (
      output Opcode, FuncCode, Zero,
      input  PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite,
             RegWrite, RegDst, MemToReg, SignExtend, ALUSrcA, ALUSrcB, ALUOp,
             PCSource, State, IllegalOp, InstrDone
   );

   modport slave (
      input  Opcode, FuncCode, Zero,
      output PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite,
             RegWrite, RegDst, MemToReg, SignExtend, ALUSrcA, ALUSrcB, ALUOp,
             PCSource, State, IllegalOp, InstrDone
   );
endinterface

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-subset controller: Moore FSM, one state per cycle; memory states last MEM_WAIT+1 cycles.
// No backpressure: memory latency is absorbed by the fixed wait count; PCEn is the only combinational path (from Zero).
module multi_cycle_control #(
   parameter int MEM_WAIT = 0
) (
   input  logic                    CLK,
   input  logic                    Reset_L,
   multi_cycle_control_if.slave    io_ctl
);

   localparam logic [3:0] S_RESET     = 4'd0;
   localparam logic [3:0] S_FETCH     = 4'd1;
   localparam logic [3:0] S_DECODE    = 4'd2;
   localparam logic [3:0] S_MEM_ADDR  = 4'd3;
   localparam logic [3:0] S_MEM_READ  = 4'd4;
   localparam logic [3:0] S_MEM_WB    = 4'd5;
   localparam logic [3:0] S_MEM_WRITE = 4'd6;
   localparam logic [3:0] S_R_EXEC    = 4'd7;
   localparam logic [3:0] S_R_WB      = 4'd8;
   localparam logic [3:0] S_BRANCH    = 4'd9;
   localparam logic [3:0] S_JUMP      = 4'd10;
   localparam logic [3:0] S_I_EXEC    = 4'd11;
   localparam logic [3:0] S_I_WB      = 4'd12;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_FUNC = 4'b0010;
   localparam logic [3:0] ALU_AND  = 4'b0011;
   localparam logic [3:0] ALU_OR   = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;

   localparam logic [3:0] LP_MEM_WAIT = 4'(MEM_WAIT);

   logic [3:0] r_state;
   logic [3:0] w_next_state;
   logic [3:0] r_wait_cnt;
   logic [3:0] w_wait_cnt_nxt;
   logic       w_wait_done;
   logic       w_op_legal;
   logic [3:0] w_dec_state;
   logic       w_is_shift;

   assign w_wait_done = (r_wait_cnt == LP_MEM_WAIT);
   assign w_is_shift  = (io_ctl.FuncCode == 6'b000000) ||
                        (io_ctl.FuncCode == 6'b000010) ||
                        (io_ctl.FuncCode == 6'b000011);

   always_comb begin
      w_op_legal  = 1'b1;
      w_dec_state = S_FETCH;
      case (io_ctl.Opcode)
         OP_LW, OP_SW:                          w_dec_state = S_MEM_ADDR;
         OP_RTYPE:                              w_dec_state = S_R_EXEC;
         OP_BEQ:                                w_dec_state = S_BRANCH;
         OP_J:                                  w_dec_state = S_JUMP;
         OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
         OP_SLTI:                               w_dec_state = S_I_EXEC;
         default:                               w_op_legal  = 1'b0;
      endcase
   end

   // Reset pulls the FSM back asynchronously, even from the middle of a memory wait.
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         r_state    <= S_RESET;
         r_wait_cnt <= 4'd0;
      end else begin
         r_state    <= w_next_state;
         r_wait_cnt <= w_wait_cnt_nxt;
      end
   end

   always_comb begin
      w_next_state   = S_FETCH;
      w_wait_cnt_nxt = 4'd0;
      case (r_state)
         S_RESET:     w_next_state = S_FETCH;
         S_FETCH: begin
            if (w_wait_done) begin
               w_next_state = S_DECODE;
            end else begin
               w_next_state   = S_FETCH;
               w_wait_cnt_nxt = r_wait_cnt + 4'd1;
            end
         end
         S_DECODE:    w_next_state = w_dec_state;
         S_MEM_ADDR: begin
            if (io_ctl.Opcode == OP_LW) begin
               w_next_state = S_MEM_READ;
            end else if (io_ctl.Opcode == OP_SW) begin
               w_next_state = S_MEM_WRITE;
            end else begin
               w_next_state = S_FETCH;
            end
         end
         S_MEM_READ: begin
            if (w_wait_done) begin
               w_next_state = S_MEM_WB;
            end else begin
               w_next_state   = S_MEM_READ;
               w_wait_cnt_nxt = r_wait_cnt + 4'd1;
            end
         end
         S_MEM_WB:    w_next_state = S_FETCH;
         S_MEM_WRITE: begin
            if (w_wait_done) begin
               w_next_state = S_FETCH;
            end else begin
               w_next_state   = S_MEM_WRITE;
               w_wait_cnt_nxt = r_wait_cnt + 4'd1;
            end
         end
         S_R_EXEC:    w_next_state = S_R_WB;
         S_R_WB:      w_next_state = S_FETCH;
         S_BRANCH:    w_next_state = S_FETCH;
         S_JUMP:      w_next_state = S_FETCH;
         S_I_EXEC:    w_next_state = S_I_WB;
         S_I_WB:      w_next_state = S_FETCH;
         default:     w_next_state = S_FETCH;
      endcase
   end

   always_comb begin
      io_ctl.PCWrite     = 1'b0;
      io_ctl.PCWriteCond = 1'b0;
      io_ctl.IorD        = 1'b0;
      io_ctl.MemRead     = 1'b0;
      io_ctl.MemWrite    = 1'b0;
      io_ctl.IRWrite     = 1'b0;
      io_ctl.RegWrite    = 1'b0;
      io_ctl.RegDst      = 1'b0;
      io_ctl.MemToReg    = 1'b0;
      io_ctl.SignExtend  = 1'b0;
      io_ctl.ALUSrcA     = 2'b00;
      io_ctl.ALUSrcB     = 2'b00;
      io_ctl.ALUOp       = ALU_ADD;
      io_ctl.PCSource    = 2'b00;
      io_ctl.IllegalOp   = 1'b0;
      io_ctl.InstrDone   = 1'b0;
      case (r_state)
         S_FETCH: begin
            io_ctl.MemRead = 1'b1;
            io_ctl.ALUSrcB = 2'b01;
            // IR and PC+4 commit only once the memory data is valid.
            io_ctl.IRWrite = w_wait_done;
            io_ctl.PCWrite = w_wait_done;
         end
         S_DECODE: begin
            io_ctl.ALUSrcB    = 2'b11;
            io_ctl.SignExtend = 1'b1;
            io_ctl.IllegalOp  = !w_op_legal;
            io_ctl.InstrDone  = !w_op_legal;
         end
         S_MEM_ADDR: begin
            io_ctl.ALUSrcA    = 2'b01;
            io_ctl.ALUSrcB    = 2'b10;
            io_ctl.SignExtend = 1'b1;
         end
         S_MEM_READ: begin
            io_ctl.MemRead = 1'b1;
            io_ctl.IorD    = 1'b1;
         end
         S_MEM_WB: begin
            io_ctl.RegWrite  = 1'b1;
            io_ctl.MemToReg  = 1'b1;
            io_ctl.InstrDone = 1'b1;
         end
         S_MEM_WRITE: begin
            io_ctl.MemWrite  = 1'b1;
            io_ctl.IorD      = 1'b1;
            io_ctl.InstrDone = w_wait_done;
         end
         S_R_EXEC: begin
            io_ctl.ALUSrcA = w_is_shift ? 2'b10 : 2'b01;
            io_ctl.ALUOp   = ALU_FUNC;
         end
         S_R_WB: begin
            io_ctl.RegWrite  = 1'b1;
            io_ctl.RegDst    = 1'b1;
            io_ctl.InstrDone = 1'b1;
         end
         S_BRANCH: begin
            io_ctl.ALUSrcA     = 2'b01;
            io_ctl.ALUOp       = ALU_SUB;
            io_ctl.PCWriteCond = 1'b1;
            io_ctl.PCSource    = 2'b01;
            io_ctl.InstrDone   = 1'b1;
         end
         S_JUMP: begin
            io_ctl.PCWrite   = 1'b1;
            io_ctl.PCSource  = 2'b10;
            io_ctl.InstrDone = 1'b1;
         end
         S_I_EXEC: begin
            io_ctl.ALUSrcA    = 2'b01;
            io_ctl.ALUSrcB    = 2'b10;
            io_ctl.SignExtend = 1'b1;
            case (io_ctl.Opcode)
               OP_ANDI: begin
                  io_ctl.ALUOp      = ALU_AND;
                  io_ctl.SignExtend = 1'b0;
               end
               OP_ORI: begin
                  io_ctl.ALUOp      = ALU_OR;
                  io_ctl.SignExtend = 1'b0;
               end
               OP_SLTI: io_ctl.ALUOp = ALU_SLT;
               default: io_ctl.ALUOp = ALU_ADD;
            endcase
         end
         S_I_WB: begin
            io_ctl.RegWrite  = 1'b1;
            io_ctl.InstrDone = 1'b1;
         end
         default: ;
      endcase
   end

   assign io_ctl.PCEn  = io_ctl.PCWrite | (io_ctl.PCWriteCond & io_ctl.Zero);
   assign io_ctl.State = r_state;

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Parameter: MEM_WAIT, default 0, extra wait cycles held in each memory-access state (FETCH, MEM_READ, MEM_WRITE); legal range 0..15.
REQ-002 CLK  in  1  clock; state, counter and all registers update on posedge.
REQ-003 Reset_L  in  1  reset, asynchronous, active-low.
REQ-004 Opcode  in  6  inst[31:26] from the instruction register.
REQ-005 FuncCode  in  6  inst[5:0] from the instruction register.
REQ-006 Zero  in  1  ALU zero flag.
REQ-007 PCWrite, PCWriteCond, PCEn  out  1 each  unconditional PC write, branch PC write, final PC enable.
REQ-008 IorD, MemRead, MemWrite, IRWrite  out  1 each  memory address select (0=PC, 1=ALUOut), memory strobes, IR load.
REQ-009 RegWrite, RegDst, MemToReg, SignExtend  out  1 each  regfile write, write-address select (1=rd), writeback select (1=memory), immediate extension (1=sign).
REQ-010 ALUSrcA  out  2  00=PC, 01=BusA, 10=shamt.
REQ-011 ALUSrcB  out  2  00=BusB, 01=constant 4, 10=extended imm, 11=extended imm<<2.
REQ-012 ALUOp  out  4  0000=add, 0001=sub, 0010=use FuncCode, 0011=and, 0100=or, 0101=slt.
REQ-013 PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump address.
REQ-014 State  out  4  current state encoding; IllegalOp, InstrDone  out  1 each  status pulses.

Function
REQ-015 State encoding SHALL be: RESET=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, I_EXEC=11, I_WB=12.
REQ-016 Outputs SHALL be Moore (decoded from State, Opcode, FuncCode); any output not listed for a state SHALL be 0.
REQ-017 PCEn SHALL equal PCWrite | (PCWriteCond & Zero), combinationally.
REQ-018 RESET: all outputs 0; next state FETCH.
REQ-019 FETCH: MemRead=1, ALUSrcB=01, ALUOp=add; IRWrite=1 and PCWrite=1 only on the final wait cycle; then DECODE.
REQ-020 DECODE: ALUSrcB=11, SignExtend=1, ALUOp=add; next by Opcode: 100011/101011 -> MEM_ADDR, 000000 -> R_EXEC, 000100 -> BRANCH, 000010 -> JUMP, 001000/001001/001100/001101/001010 -> I_EXEC, any other -> FETCH with IllegalOp=1 and InstrDone=1 for that cycle.
REQ-021 MEM_ADDR: ALUSrcA=01, ALUSrcB=10, SignExtend=1, ALUOp=add; lw -> MEM_READ, sw -> MEM_WRITE.
REQ-022 MEM_READ: MemRead=1, IorD=1 every wait cycle; then MEM_WB.
REQ-023 MEM_WB: RegWrite=1, MemToReg=1, RegDst=0, InstrDone=1; then FETCH.
REQ-024 MEM_WRITE: MemWrite=1, IorD=1 every wait cycle; InstrDone=1 on final cycle; then FETCH.
REQ-025 R_EXEC: ALUSrcA=10 when FuncCode is 000000/000010/000011 (shifts), else 01; ALUSrcB=00, ALUOp=0010; then R_WB.
REQ-026 R_WB: RegWrite=1, RegDst=1, InstrDone=1; then FETCH.
REQ-027 BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=sub, PCWriteCond=1, PCSource=01, InstrDone=1; then FETCH.
REQ-028 JUMP: PCWrite=1, PCSource=10, InstrDone=1; then FETCH.
REQ-029 I_EXEC: ALUSrcA=01, ALUSrcB=10; ALUOp add (addi, addiu), and (andi), or (ori), slt (slti); SignExtend=0 for andi/ori, else 1; then I_WB.
REQ-030 I_WB: RegWrite=1, RegDst=0, MemToReg=0, InstrDone=1; then FETCH.
REQ-031 Wait counter (4 bits): in a memory state, stay while count < MEM_WAIT, incrementing each cycle; leave when count == MEM_WAIT; counter cleared on every state exit, so a memory state lasts exactly MEM_WAIT+1 cycles.
REQ-032 Unused encodings 13-15: all outputs 0, next state FETCH, counter cleared.
REQ-033 Cycle counts at MEM_WAIT=0: lw 5, sw 4, R-type 4, I-type 4, beq 3, j 3.

Reset
REQ-034 Reset_L low SHALL force State=RESET and counter=0 immediately, independent of CLK, including mid-instruction and mid-wait.
REQ-035 First posedge after Reset_L rises SHALL move to FETCH; no write strobe SHALL be asserted in RESET.

Verification
REQ-036 MEM_WAIT=0, Reset_L released, Opcode=100011 -> states 0,1,2,3,4,5,1; RegWrite=MemToReg=1 only in state 5.
REQ-037 Opcode=000100: Zero=1 -> PCEn=1 in BRANCH; Zero=0 -> PCEn=0; both take 3 cycles.
REQ-038 Opcode=000000, FuncCode=000010 -> ALUSrcA=10 in R_EXEC; FuncCode=100000 -> ALUSrcA=01; ALUOp=0010 both.
REQ-039 Opcode=111111 -> DECODE with IllegalOp=1, InstrDone=1, then FETCH; no RegWrite/MemWrite.
REQ-040 MEM_WAIT=2, Opcode=101011 -> FETCH 3 cycles (IRWrite on third only), MEM_WRITE 3 cycles with MemWrite=1.
REQ-041 Reset_L pulsed low during MEM_READ wait -> State=0 asynchronously, all outputs 0, FETCH on next posedge after release.
